// File: rtl/par2sep_pixel.sv
// par2sep_pixel -- parallel-to-serial pixel converter.
//
// Accepts a packed word of SHIFT_WIDTH pixels and emits it one pixel per
// output transfer, oldest (MS slice) first. Tracks the line position of every
// emitted pixel so that start-of-line and end-of-line can be flagged, and lets
// din_sol resynchronise the line position, raising a sticky error when the
// resync lands off a line boundary.
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   din         packed word, oldest pixel in the MS slice
//   din_valid   din is valid
//   din_ready   word accepted this cycle when din_valid is also high
//   din_sol     word is the first of a line (qualified by din_valid)
//   dout        serial pixel
//   dout_valid  dout is valid
//   dout_ready  downstream accepts dout
//   dout_sync   dout is pixel 0 of a line
//   dout_eol    dout is pixel LINE_PIXELS-1 of a line
//   err_align   sticky: din_sol arrived off a line boundary
module par2sep_pixel #(
  parameter int SEP_DATA_WIDTH = 24,
  parameter int SHIFT_WIDTH    = 8,
  parameter int LINE_PIXELS    = 1920
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [SHIFT_WIDTH*SEP_DATA_WIDTH-1:0] din,
  input  logic                                  din_valid,
  output logic                                  din_ready,
  input  logic                                  din_sol,
  output logic [SEP_DATA_WIDTH-1:0]             dout,
  output logic                                  dout_valid,
  input  logic                                  dout_ready,
  output logic                                  dout_sync,
  output logic                                  dout_eol,
  output logic                                  err_align
);

  localparam int SLOT_W = $clog2(SHIFT_WIDTH);
  localparam int PIX_W  = $clog2(LINE_PIXELS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SHIFT_WIDTH - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LINE_PIXELS - 1);

  typedef enum logic {EMPTY, SHIFT} state_e;

  state_e                                        state_q, state_d;
  logic [SLOT_W-1:0]                             slot_q, slot_d;
  logic [SHIFT_WIDTH-1:0][SEP_DATA_WIDTH-1:0]    word_q, word_d;
  logic [PIX_W-1:0]                              pix_cnt_q, pix_cnt_d;
  logic                                          err_q, err_d;
  // Gates din_ready until the first edge after reset release.
  logic                                          rdy_en_q;

  logic in_xfer;
  logic out_xfer;

  // din_ready looks at dout_ready combinationally so that the next word can
  // be taken in the same cycle the last pixel of the current one leaves.
  assign din_ready  = rdy_en_q &
                      ((state_q == EMPTY) ||
                       ((slot_q == SLOT_LAST) && dout_ready));
  assign dout_valid = (state_q == SHIFT);
  assign in_xfer    = din_valid & din_ready;
  assign out_xfer   = dout_valid & dout_ready;

  // Slot 0 reads the MS slice; slot k reads slice SHIFT_WIDTH-1-k.
  assign dout      = dout_valid ? word_q[SLOT_LAST - slot_q] : '0;
  assign dout_sync = dout_valid && (pix_cnt_q == '0);
  assign dout_eol  = dout_valid && (pix_cnt_q == PIX_LAST);
  assign err_align = err_q;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    word_d    = word_q;
    pix_cnt_d = pix_cnt_q;
    err_d     = err_q;

    if (out_xfer) begin
      pix_cnt_d = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + PIX_W'(1);
    end

    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          word_d  = din;
          slot_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (out_xfer) begin
          if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            if (in_xfer) begin
              word_d = din;
            end else begin
              state_d = EMPTY;
            end
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      default: state_d = EMPTY;
    endcase

    // pix_cnt_d already holds the position the new word's first pixel would
    // have had; the previous word's last pixel has been counted normally.
    if (in_xfer && din_sol) begin
      if (pix_cnt_d != '0) begin
        err_d = 1'b1;
      end
      pix_cnt_d = '0;
    end
  end

  // NOTE: the held word is a plain register, not a memory, so it is reset to
  // keep dout at zero out of reset and to drop any partially emitted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      slot_q    <= '0;
      word_q    <= '0;
      pix_cnt_q <= '0;
      err_q     <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state_q   <= state_d;
      slot_q    <= slot_d;
      word_q    <= word_d;
      pix_cnt_q <= pix_cnt_d;
      err_q     <= err_d;
      rdy_en_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_par2sep_pixel.sv
// Testbench for par2sep_pixel: scoreboard of expected pixels (with line sync
// and end-of-line flags) filled as words are accepted and drained as the DUT
// emits pixels.
module tb_par2sep_pixel;

  localparam int DW   = 24;
  localparam int SW   = 8;
  localparam int LINE = 16;

  typedef struct {
    logic [DW-1:0] pix;
    logic          sync;
    logic          eol;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [SW*DW-1:0]  din;
  logic              din_valid;
  logic              din_ready;
  logic              din_sol;
  logic [DW-1:0]     dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_sync;
  logic              dout_eol;
  logic              err_align;

  par2sep_pixel #(
    .SEP_DATA_WIDTH(DW),
    .SHIFT_WIDTH   (SW),
    .LINE_PIXELS   (LINE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din_sol   (din_sol),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_sync (dout_sync),
    .dout_eol  (dout_eol),
    .err_align (err_align)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  int   model_pos = 0;
  logic exp_err   = 1'b0;
  int   rdy_mode  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // dout_ready driver: always 1, or the repeating 1,0,0,1 pattern.
  initial begin
    logic [3:0] pat;
    int idx;
    pat = 4'b1001;
    idx = 0;
    dout_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
        dout_ready = 1'b1;
      end else begin
        dout_ready = pat[3-idx];
        idx = (idx + 1) % 4;
      end
    end
  end

  // Output monitor: scoreboard compare, stall stability, no ready while stalled.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_dout;
  logic          prev_sync, prev_eol;
  exp_t          got_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_dout", dout, prev_dout);
        check("hold_sync", dout_sync, prev_sync);
        check("hold_eol", dout_eol, prev_eol);
      end
      if (dout_valid && !dout_ready) check("stall_din_ready", din_ready, 0);
      if (dout_valid && dout_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          got_e = sb.pop_front();
          check("dout", dout, got_e.pix);
          check("dout_sync", dout_sync, got_e.sync);
          check("dout_eol", dout_eol, got_e.eol);
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
      prev_sync  = dout_sync;
      prev_eol   = dout_eol;
    end
  end

  // Line model: applied when a word is accepted.
  task automatic push_word(input logic [SW*DW-1:0] w, input logic sol);
    exp_t e;
    if (sol) begin
      if (model_pos != 0) exp_err = 1'b1;
      model_pos = 0;
    end
    for (int i = 0; i < SW; i++) begin
      e.pix  = w[(SW-1-i)*DW +: DW];
      e.sync = (model_pos == 0);
      e.eol  = (model_pos == LINE - 1);
      sb.push_back(e);
      model_pos = (model_pos + 1) % LINE;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_word(input logic [SW*DW-1:0] w, input logic sol);
    bit ok;
    ok = 0;
    din       = w;
    din_sol   = sol;
    din_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (din_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
    end else begin
      push_word(w, sol);
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    din_sol   = 1'b0;
    din       = {SW{24'hA5A5A5}};
  endtask

  task automatic send_rand(input logic sol);
    logic [SW*DW-1:0] w;
    for (int i = 0; i < SW; i++) w[i*DW +: DW] = DW'($urandom);
    send_word(w, sol);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !dout_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [SW*DW-1:0] w;
    bit found;
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    din_sol   = 1'b0;

    // Reset state.
    #12;
    check("rst_dout_valid", dout_valid, 0);
    check("rst_din_ready", din_ready, 0);
    check("rst_dout", dout, 0);
    check("rst_sync", dout_sync, 0);
    check("rst_eol", dout_eol, 0);
    check("rst_err", err_align, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("rel_din_ready_before_edge", din_ready, 0);
    @(posedge clk);
    #1 check("din_ready_after_edge", din_ready, 1);

    // Single word 1..8 with sol.
    for (int i = 0; i < SW; i++) w[(SW-1-i)*DW +: DW] = DW'(i + 1);
    send_word(w, 1'b1);
    check("single_valid_latency1", dout_valid, 1);
    check("single_first_pixel", dout, 24'h000001);
    drain();
    check("single_err", err_align, 0);

    // Back-to-back 3 words: no bubble, din_ready only at offsets 8, 16, 24.
    fork
      begin
        send_rand(1'b0);
        send_rand(1'b0);
        send_rand(1'b0);
      end
      begin
        found = 0;
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (din_valid && din_ready) begin
            found = 1;
            break;
          end
        end
        if (!found) check("burst_start_timeout", 0, 1);
        else begin
          for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            check("burst_valid", dout_valid, 1);
            check("burst_din_ready", din_ready, (k % 8 == 0));
          end
        end
      end
    join
    drain();

    // Backpressure with 1,0,0,1 pattern.
    rdy_mode = 1;
    send_rand(1'b0);
    send_rand(1'b0);
    drain();
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Line wrap: 4 words, sol on the first only (position is already 0 here).
    send_rand(1'b1);
    send_rand(1'b0);
    send_rand(1'b0);
    send_rand(1'b0);
    drain();
    check("wrap_err", err_align, 0);

    // Misalignment: sol on words 0 and 1.
    send_rand(1'b1);
    send_rand(1'b1);
    drain();
    check("misalign_model_err", exp_err, 1);
    check("misalign_err", err_align, 1);
    send_rand(1'b0);
    drain();
    check("misalign_err_sticky", err_align, 1);

    // Reset at slot 3 of a word.
    send_rand(1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dout_valid", dout_valid, 0);
    check("midrst_din_ready", din_ready, 0);
    check("midrst_err", err_align, 0);
    sb.delete();
    model_pos = 0;
    exp_err   = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("midrst_rel_din_ready", din_ready, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < SW; i++) w[(SW-1-i)*DW +: DW] = DW'(24'h100 + i);
    send_word(w, 1'b0);
    check("post_rst_first_pixel", dout, 24'h000100);
    check("post_rst_sync", dout_sync, 1);
    drain();
    check("post_rst_err", err_align, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
